fetch_unit: RTL
===============

FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, giving the address width.
REQ-002 The block SHALL have parameter RESET_VECTOR, default 32'h00400000, giving the first fetch address.
REQ-003 The block SHALL have one clock and an asynchronous, active-high reset; the ports SHALL be named clock and reset.
REQ-004 Ports SHALL be, in this order (name  direction  width  meaning):
- clock  in  1  rising-edge clock
- reset  in  1  async active-high reset
- pc_current  out  WIDTH  current fetch PC; drives the PC+4 adder operand_a (operand_b tied to 4 externally)
- pc_plus_4  in  WIDTH  adder result, pc_current + 4
- redirect_valid  in  1  branch/jump/trap redirect this cycle
- redirect_target  in  WIDTH  redirect address
- imem_req_valid  out  1  fetch request valid
- imem_req_addr  out  WIDTH  fetch address, equal to pc_current
- imem_req_ready  in  1  memory accepts request
- imem_resp_valid  in  1  instruction word returned
- imem_resp_data  in  32  instruction word
- inst_valid  out  1  buffered instruction available
- inst_data  out  32  instruction at buffer head
- inst_pc  out  WIDTH  address of inst_data
- inst_ready  in  1  decode stage consumes head

Function
REQ-005 Request handshake: a request is accepted when imem_req_valid and imem_req_ready are both 1 on a rising edge.
REQ-006 Instruction handshake: the head entry is consumed when inst_valid and inst_ready are both 1 on a rising edge.
REQ-007 Memory responses SHALL be assumed in order, with latency of at least 1 cycle and no backpressure.
REQ-008 The block SHALL contain a 2-entry {data, pc} instruction FIFO and a 2-entry in-flight address FIFO.
REQ-009 The outstanding count (0..2) SHALL include requests marked for drop.
REQ-010 imem_req_valid SHALL be 1 iff outstanding + FIFO occupancy < 2; it SHALL depend only on registered state.
REQ-011 On an accepted request, the block SHALL push pc_current into the address FIFO and load pc_current <= pc_plus_4.
REQ-012 pc_current SHALL hold its value when no request is accepted and no redirect occurs.
REQ-013 On a non-dropped response, the block SHALL pop the address FIFO and write {imem_resp_data, popped address} into the instruction FIFO.
REQ-014 A response SHALL appear on inst_valid on the next cycle; there is no combinational bypass.
REQ-015 inst_valid SHALL be 1 iff the FIFO is non-empty; inst_data and inst_pc SHALL be driven from the head entry.
REQ-016 Head values SHALL be stable while inst_valid is 1 and inst_ready is 0.
REQ-017 Redirect SHALL have priority over every other update, taking effect at the rising edge where redirect_valid is 1:
- pc_current <= {redirect_target[WIDTH-1:2], 2'b00}
- instruction FIFO emptied
- drop count <= outstanding after this edge, including a request accepted in the same cycle
REQ-018 When the drop count is non-zero, the next responses SHALL be discarded and each SHALL decrement both drop count and outstanding; a response arriving in the redirect cycle itself SHALL be discarded.
REQ-019 Issue after a redirect: requests SHALL be issued to the new PC in the cycle after the redirect, subject to REQ-010.
REQ-020 An instruction handshake in the same cycle as a redirect SHALL count as delivered; the remaining entries SHALL be flushed.
REQ-021 A simultaneous push and pop on the full FIFO SHALL be legal when the pop frees the slot.
- Pointers SHALL wrap modulo 2.
- Occupancy SHALL never exceed 2.
- Outstanding SHALL never exceed 2.
REQ-022 A response with outstanding = 0 is a protocol error; it SHALL be ignored without changing state.

Reset
REQ-023 While reset is 1, the following SHALL hold:
- pc_current = RESET_VECTOR
- both FIFOs empty; outstanding = 0; drop count = 0
- imem_req_valid = 0; inst_valid = 0
- inst_data = 0; inst_pc = 0
REQ-024 Reset assertion mid-operation SHALL abandon all in-flight requests; responses arriving after reset deasserts SHALL be ignored per REQ-022.
REQ-025 imem_req_valid SHALL go to 1 in the first cycle after reset deasserts.

Verification
REQ-026 Streaming: memory with 1-cycle latency, imem_req_ready = 1, inst_ready = 1 -> inst_pc sequence 0x00400000, 0x00400004, 0x00400008, with each inst_data matching memory contents.
REQ-027 Backpressure: inst_ready = 0 -> after 2 responses, imem_req_valid = 0 and pc_current = 0x00400008; the head stays at 0x00400000 until inst_ready = 1.
REQ-028 Redirect with 2 outstanding: redirect_target = 0x00400103 -> the next 2 responses are discarded and the first delivered inst_pc = 0x00400100.
REQ-029 Same-cycle events: redirect, request accept and instruction handshake all in one cycle -> the consumed entry is delivered once, the accepted request is dropped, and pc_current = target.
REQ-030 Reset mid-fetch: assert reset with 2 outstanding -> all outputs take their reset values immediately; late responses do not produce inst_valid.

Source files
------------

// File: rtl/fetch_unit.sv
// Instruction fetch unit: PC register, in-flight address FIFO and a 2-entry
// {data, pc} instruction FIFO. Redirects flush the instruction FIFO and mark
// every still-outstanding request for drop so its response is discarded.
module fetch_unit #(
   parameter int               WIDTH        = 32,
   parameter logic [WIDTH-1:0] RESET_VECTOR = 'h0040_0000
) (
   input  logic             clock,
   input  logic             reset,
   output logic [WIDTH-1:0] pc_current,
   input  logic [WIDTH-1:0] pc_plus_4,
   input  logic             redirect_valid,
   input  logic [WIDTH-1:0] redirect_target,
   output logic             imem_req_valid,
   output logic [WIDTH-1:0] imem_req_addr,
   input  logic             imem_req_ready,
   input  logic             imem_resp_valid,
   input  logic [31:0]      imem_resp_data,
   output logic             inst_valid,
   output logic [31:0]      inst_data,
   output logic [WIDTH-1:0] inst_pc,
   input  logic             inst_ready
);

   logic [WIDTH-1:0] pc_q;
   logic             run_q;

   // in-flight address FIFO; its occupancy is the outstanding count
   logic [WIDTH-1:0] addr_q [2];
   logic             a_wr_q;
   logic             a_rd_q;
   logic [1:0]       out_cnt_q;
   logic [1:0]       drop_cnt_q;

   // instruction FIFO
   logic [31:0]      idata_q [2];
   logic [WIDTH-1:0] ipc_q   [2];
   logic             i_wr_q;
   logic             i_rd_q;
   logic [1:0]       i_cnt_q;

   logic [2:0]       occ_sum;
   logic             req_fire;
   logic             resp_any;
   logic             resp_drop;
   logic             resp_keep;
   logic             inst_pop;
   logic [1:0]       out_cnt_nxt;
   logic             tgt_lsb_unused;

   assign occ_sum        = {1'b0, out_cnt_q} + {1'b0, i_cnt_q};
   // run_q keeps requests off while reset is held and enables them one edge later
   assign imem_req_valid = run_q && (occ_sum < 3'd2);
   assign imem_req_addr  = pc_q;
   assign pc_current     = pc_q;

   assign req_fire  = imem_req_valid && imem_req_ready;
   // a response with nothing outstanding is a protocol error and is ignored
   assign resp_any  = imem_resp_valid && (out_cnt_q != 2'd0);
   assign resp_drop = resp_any && (redirect_valid || (drop_cnt_q != 2'd0));
   assign resp_keep = resp_any && !resp_drop;
   assign inst_pop  = inst_valid && inst_ready;

   assign out_cnt_nxt = out_cnt_q + {1'b0, req_fire} - {1'b0, resp_any};

   assign inst_valid = (i_cnt_q != 2'd0);
   // stale storage is masked so the outputs read zero whenever the FIFO is empty
   assign inst_data  = inst_valid ? idata_q[i_rd_q] : 32'd0;
   assign inst_pc    = inst_valid ? ipc_q[i_rd_q]   : '0;

   assign tgt_lsb_unused = ^redirect_target[1:0];

   // control state: PC, pointers, counters; redirect wins over normal updates
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         pc_q       <= RESET_VECTOR;
         run_q      <= 1'b0;
         a_wr_q     <= 1'b0;
         a_rd_q     <= 1'b0;
         out_cnt_q  <= 2'd0;
         drop_cnt_q <= 2'd0;
         i_wr_q     <= 1'b0;
         i_rd_q     <= 1'b0;
         i_cnt_q    <= 2'd0;
      end else begin
         run_q     <= 1'b1;
         out_cnt_q <= out_cnt_nxt;
         if (req_fire) a_wr_q <= ~a_wr_q;
         if (resp_any) a_rd_q <= ~a_rd_q;
         if (redirect_valid) begin
            pc_q       <= {redirect_target[WIDTH-1:2], 2'b00};
            drop_cnt_q <= out_cnt_nxt;
            i_wr_q     <= 1'b0;
            i_rd_q     <= 1'b0;
            i_cnt_q    <= 2'd0;
         end else begin
            if (req_fire)  pc_q       <= pc_plus_4;
            if (resp_drop) drop_cnt_q <= drop_cnt_q - 2'd1;
            if (resp_keep) i_wr_q     <= ~i_wr_q;
            if (inst_pop)  i_rd_q     <= ~i_rd_q;
            i_cnt_q <= i_cnt_q + {1'b0, resp_keep} - {1'b0, inst_pop};
         end
      end
   end

   // FIFO storage writes; contents are qualified by the counters above
   always_ff @(posedge clock) begin
      if (req_fire) addr_q[a_wr_q] <= pc_q;
      if (resp_keep) begin
         idata_q[i_wr_q] <= imem_resp_data;
         ipc_q[i_wr_q]   <= addr_q[a_rd_q];
      end
   end

endmodule
